step_pulse_gen: RTL
===================

Name: step_pulse_gen

Overview:
Synthetic step-pulse source for the fitness-tracker datapath. Emits single-cycle step strobes at a selectable per-second rate (walk, jog, run, or scripted hybrid profile) and a one-second tick. Sits directly upstream of the speed/step-statistics stage, which consumes stepPulse as its pulse input and secondTick as its second boundary. All logic runs on one system clock; no derived clocks.

Parameters:
CLK_HZ, 100000000, system clock cycles per second (benches use 1000)
RATE_W, 8, width of the rate and elapsed-seconds fields

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  level; high = generate, low = idle and clear counters
mode  in  2  00 walk, 01 jog, 10 run, 11 hybrid
stepPulse  out  1  one-cycle strobe per generated step
secondTick  out  1  one-cycle strobe on the last cycle of each second
rate  out  RATE_W  pulses/s in force for the current second
elapsedSec  out  RATE_W  completed seconds since start, saturates at 255

Behaviour:
- Reset: stepPulse=0, secondTick=0, rate=0, elapsedSec=0. Cycle counter, accumulator and hybrid index are 0. State is IDLE.
- FSM has two states:
  - IDLE: outputs 0, counters held at 0. Moves to RUN on the first clk edge with start=1. mode is sampled on that edge and sets rate.
  - RUN: returns to IDLE on any edge with start=0. Counters clear on that same edge, and no stepPulse appears on or after that edge.
- Rate table: walk=32, jog=64, run=128.
- Hybrid rate is indexed by elapsedSec:
  - seconds 0..8: 20, 33, 66, 27, 70, 30, 19, 30, 33
  - seconds 9..72: 69
  - seconds 73..78: 34
  - seconds 79..143: 124
  - second 144 onward: 0
- Rate latching: mode and rate are latched only at second boundaries. A mode change mid-second takes effect at the next second.
- Second counter:
  - cyc counts 0..CLK_HZ-1.
  - secondTick=1 in the cycle where cyc==CLK_HZ-1.
  - On that edge: cyc wraps to 0, elapsedSec increments (saturating at 255), the accumulator clears, and the rate is re-latched.
- Pulse generation uses a phase accumulator, width clog2(CLK_HZ+2^RATE_W)+1.
  - Each RUN cycle computes nxt = acc + rate.
  - If nxt >= CLK_HZ: stepPulse=1 that cycle (combinational from registered state) and acc <= nxt - CLK_HZ. Otherwise acc <= nxt.
  - Result: exactly rate pulses per second, evenly spaced, with the first pulse in cycle index ceil(CLK_HZ/rate)-1 of the second.
  - rate=0 produces no pulses.
- Simultaneous events:
  - stepPulse and secondTick may both be 1 in the same cycle. The accumulator clear wins over the residue.
  - reset overrides everything asynchronously.
  - start low overrides a secondTick on the same edge.
- stepPulse is never high for two consecutive cycles, because rate <= 128 is far below CLK_HZ.

Decomposition:
- Package step_pkg holds:
  - mode constants MODE_WALK/JOG/RUN/HYBRID
  - rate constants RATE_WALK=32, RATE_JOG=64, RATE_RUN=128
  - function hybrid_rate(sec) returning the scripted schedule
- One sub-module, rate_accumulator: accumulator, compare/subtract, pulse output, and synchronous clear input.
- The top holds the FSM, cycle counter, elapsedSec and the rate latch.

Test Plan:
(All with CLK_HZ=1000.)
- Walk: reset, mode=00, start=1 for 3000 cycles -> exactly 32 stepPulse per second. First pulse at cycle 31 of second 0. elapsedSec=3. Three secondTicks, 1000 cycles apart.
- Run then jog switch: mode=10, switch to 01 at cycle 500 -> 128 pulses in second 0, 64 pulses in second 1. rate changes only at cycle 1000.
- Hybrid: mode=11, run 12 s -> per-second counts 20, 33, 66, 27, 70, 30, 19, 30, 33, 69, 69, 69. rate output matches each second.
- Hybrid tail: run 150 s -> seconds 73..78 give 34 pulses, 79..143 give 124, 144+ give 0. elapsedSec=150.
- Start drop: start low at cycle 1500 -> no stepPulse from that edge onward, elapsedSec=0 next cycle. start high again -> the second restarts from cyc 0 with the first pulse at cycle 31.
- Async reset mid-run: assert reset between edges at cycle 2700 -> all outputs 0 immediately. After release with start=1, counts restart from second 0.

Source files
------------

// File: rtl/step_pkg.sv
// Shared types and rate schedule for the synthetic step-pulse source.
// Mode encodings, fixed step rates and the scripted hybrid workout profile.
package step_pkg;

  typedef enum logic [1:0] {
    MODE_WALK   = 2'b00,
    MODE_JOG    = 2'b01,
    MODE_RUN    = 2'b10,
    MODE_HYBRID = 2'b11
  } mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] RATE_WALK = 8'd32;
  localparam logic [7:0] RATE_JOG  = 8'd64;
  localparam logic [7:0] RATE_RUN  = 8'd128;

  // Scripted profile: irregular warm-up, steady block, easy block, sprint block, then rest.
  function automatic logic [7:0] hybrid_rate(input int unsigned sec);
    logic [7:0] r;
    case (sec)
      0:       r = 8'd20;
      1:       r = 8'd33;
      2:       r = 8'd66;
      3:       r = 8'd27;
      4:       r = 8'd70;
      5:       r = 8'd30;
      6:       r = 8'd19;
      7:       r = 8'd30;
      8:       r = 8'd33;
      default: begin
        if (sec <= 72)       r = 8'd69;
        else if (sec <= 78)  r = 8'd34;
        else if (sec <= 143) r = 8'd124;
        else                 r = 8'd0;
      end
    endcase
    return r;
  endfunction

  function automatic logic [7:0] mode_rate(input mode_t m, input int unsigned sec);
    logic [7:0] r;
    case (m)
      MODE_WALK: r = RATE_WALK;
      MODE_JOG:  r = RATE_JOG;
      MODE_RUN:  r = RATE_RUN;
      default:   r = hybrid_rate(sec);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Control and strobe bundle between the step-pulse source and its consumer.
// start is a level (no handshake); stepPulse and secondTick are single-cycle strobes with no backpressure.
interface step_pulse_gen_if #(
  parameter int RATE_W = 8
);
  import step_pkg::*;

  logic              start;
  logic [1:0]        mode;
  logic              stepPulse;
  logic              secondTick;
  logic [RATE_W-1:0] rate;
  logic [RATE_W-1:0] elapsedSec;
  state_t            dbgState;

  modport master (
    output start, mode,
    input  stepPulse, secondTick, rate, elapsedSec, dbgState
  );

  modport slave (
    input  start, mode,
    output stepPulse, secondTick, rate, elapsedSec, dbgState
  );

endinterface

// File: rtl/rate_accumulator.sv
// Phase accumulator: adds rate every enabled cycle and strobes pulse on each CLK_HZ overflow.
// clear has priority over the residue so each second starts from phase zero.
module rate_accumulator #(
  parameter int CLK_HZ = 100000000,
  parameter int RATE_W = 8,
  parameter int ACC_W  = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              pulse
);

  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;

  assign nxt   = acc + ACC_W'(rate);
  assign pulse = en && (nxt >= LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= pulse ? (nxt - LIMIT) : nxt;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Synthetic step-pulse source: per-second rate selection, second tick and elapsed-seconds count.
// Rate is re-latched only at second boundaries; the accumulator turns it into evenly spaced strobes.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int RATE_W = 8
) (
  input logic        clk,
  input logic        reset,
  step_pulse_gen_if.slave bus
);

  localparam int CYC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int ACC_W = $clog2(CLK_HZ + (1 << RATE_W)) + 1;
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(CLK_HZ - 1);
  localparam logic [RATE_W-1:0] SEC_MAX  = '1;

  state_t            state;
  state_t            nextState;
  logic [CYC_W-1:0]  cyc;
  logic [CYC_W-1:0]  cycNext;
  logic [RATE_W-1:0] rateReg;
  logic [RATE_W-1:0] rateNext;
  logic [RATE_W-1:0] secReg;
  logic [RATE_W-1:0] secNext;
  logic              tick;
  logic              accEn;
  logic              accClear;
  logic              pulse;

  assign tick = (state == ST_RUN) && (cyc == CYC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Dropping start wins over a coincident second boundary: everything returns to zero.
  always_comb begin
    nextState = state;
    cycNext   = cyc;
    secNext   = secReg;
    rateNext  = rateReg;
    accEn     = 1'b0;
    accClear  = 1'b0;
    case (state)
      ST_IDLE: begin
        accClear = 1'b1;
        cycNext  = '0;
        secNext  = '0;
        rateNext = '0;
        if (bus.start) begin
          nextState = ST_RUN;
          rateNext  = RATE_W'(mode_rate(mode_t'(bus.mode), 32'd0));
        end
      end
      ST_RUN: begin
        accEn = 1'b1;
        if (!bus.start) begin
          nextState = ST_IDLE;
          cycNext   = '0;
          secNext   = '0;
          rateNext  = '0;
          accClear  = 1'b1;
        end else if (tick) begin
          cycNext  = '0;
          secNext  = (secReg == SEC_MAX) ? secReg : secReg + 1'b1;
          rateNext = RATE_W'(mode_rate(mode_t'(bus.mode), 32'(secNext)));
          accClear = 1'b1;
        end else begin
          cycNext = cyc + 1'b1;
        end
      end
      default: begin
        nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc     <= '0;
      secReg  <= '0;
      rateReg <= '0;
    end else begin
      cyc     <= cycNext;
      secReg  <= secNext;
      rateReg <= rateNext;
    end
  end

  rate_accumulator #(
    .CLK_HZ (CLK_HZ),
    .RATE_W (RATE_W),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .en    (accEn),
    .clear (accClear),
    .rate  (rateReg),
    .pulse (pulse)
  );

  assign bus.stepPulse  = pulse;
  assign bus.secondTick = tick;
  assign bus.rate       = rateReg;
  assign bus.elapsedSec = secReg;
  assign bus.dbgState   = state;

endmodule
